step_ctrl: RTL and testbench

Single-step and free-run controller upstream of the single-cycle RISC-V core. Debounces the raw push-button, converts each confirmed press into a one-cycle `step_en` pulse, and in run mode generates periodic `step_en` pulses from a divider. `step_en` drives the clock enable for the PC, register file and data memory, so all core state advances on `clk`. This replaces the raw push-button clock. Also counts executed steps for display on the SSD.

---
 rtl/step_ctrl.sv | 122 ++++++++++++
 tb/tb_step_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_ctrl.sv
// Step controller: debounced single-step button and divided free-run pulse.
// Produces the core clock enable and counts executed steps.
module step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int RUN_DIV         = 50_000_000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_raw,
    input  logic             run_mode,
    input  logic             halt,
    output logic             step_en,
    output logic [CNT_W-1:0] step_count,
    output logic             btn_level,
    output logic             running
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DW = $clog2(RUN_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic          btn_m;
    logic          btn_s;
    logic          run_m;
    logic          run_s;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] div;
    logic          press_evt;
    logic          div_tc;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
            run_m <= 1'b0;
            run_s <= 1'b0;
        end else begin
            btn_m <= btn_raw;
            btn_s <= btn_m;
            run_m <= run_mode;
            run_s <= run_m;
        end
    end

    assign press_evt = (state == PRESS_WAIT) && btn_s && (cnt == CNT_MAX);
    assign div_tc    = run_s && !halt && (div == DIV_MAX);

    // Press events are dropped in run mode so the two pulse sources never mix.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            step_en    <= 1'b0;
            step_count <= '0;
            btn_level  <= 1'b0;
            running    <= 1'b0;
        end else begin
            step_en    <= (press_evt && !run_s) || div_tc;
            step_count <= step_count + CNT_W'(step_en);
            btn_level  <= (state == PRESSED) || (state == RELEASE_WAIT);
            running    <= run_s & ~halt;
            unique case (state)
                IDLE: begin
                    if (btn_s) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s) begin
                        state <= IDLE;
                    end else if (cnt == CNT_MAX) begin
                        state <= PRESSED;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!btn_s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_s) begin
                        state <= PRESSED;
                    end else if (cnt == CNT_MAX) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Halt freezes the divider phase; leaving run mode restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
        end else if (!run_s) begin
            div <= '0;
        end else if (!halt) begin
            if (div == DIV_MAX) begin
                div <= '0;
            end else begin
                div <= div + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_step_ctrl.sv
// Bench for step_ctrl: directed scenarios plus random stimulus,
// all checked every cycle against a run-length based reference model.
module tb_step_ctrl;

    localparam int D = 4;
    localparam int R = 8;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         btn_raw = 1'b0;
    logic         run_mode = 1'b0;
    logic         halt = 1'b0;
    logic         step_en;
    logic [W-1:0] step_count;
    logic         btn_level;
    logic         running;

    int tests = 0;
    int fails = 0;

    step_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .RUN_DIV        (R),
        .CNT_W          (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .run_mode  (run_mode),
        .halt      (halt),
        .step_en   (step_en),
        .step_count(step_count),
        .btn_level (btn_level),
        .running   (running)
    );

    always #5 clk = ~clk;

    // Reference model: synchronizer delay as a 2-deep history,
    // debounce as "level flips after D+1 equal samples in a row",
    // run divider as "a pulse every R-th active cycle".
    bit b_hist[2];
    bit r_hist[2];
    bit lvl;
    int ones;
    int zeros;
    int active;
    bit e_step_en;
    int e_count;
    bit e_level;
    bit e_running;

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit bs;
        bit rs;
        bit press;
        bit pulse;
        if (rst) begin
            b_hist    = '{0, 0};
            r_hist    = '{0, 0};
            lvl       = 0;
            ones      = 0;
            zeros     = 0;
            active    = 0;
            e_step_en = 0;
            e_count   = 0;
            e_level   = 0;
            e_running = 0;
            return;
        end
        bs = b_hist[1];
        rs = r_hist[1];
        e_count   = (e_count + int'(e_step_en)) % (1 << W);
        e_level   = lvl;
        e_running = rs && !halt;
        press = 0;
        pulse = 0;
        if (bs) begin
            ones++;
            zeros = 0;
        end else begin
            zeros++;
            ones = 0;
        end
        if (!lvl && ones == D + 1) begin
            lvl   = 1;
            press = 1;
        end else if (lvl && zeros == D + 1) begin
            lvl = 0;
        end
        if (!rs) begin
            active = 0;
        end else if (!halt) begin
            active++;
            pulse = (active % R) == 0;
        end
        e_step_en = (press && !rs) || pulse;
        b_hist[1] = b_hist[0];
        b_hist[0] = btn_raw;
        r_hist[1] = r_hist[0];
        r_hist[0] = run_mode;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("step_en", int'(step_en), int'(e_step_en));
        chk("step_count", int'(step_count), e_count);
        chk("btn_level", int'(btn_level), int'(e_level));
        chk("running", int'(running), int'(e_running));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int pulses;
        int third;
        int btn_left;
        int run_left;
        bit bounce[6];

        @(negedge clk);
        btn_raw = 1'b0;
        run_mode = 1'b0;
        halt = 1'b0;
        do_reset();
        chk("rst_step_en", int'(step_en), 0);
        chk("rst_count", int'(step_count), 0);
        chk("rst_level", int'(btn_level), 0);
        chk("rst_running", int'(running), 0);
        repeat (3) tick();

        // Clean press
        btn_raw = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("press_edge", int'(step_en), int'(k == 7));
            if (k >= 8) chk("press_level", int'(btn_level), 1);
        end
        btn_raw = 1'b0;
        repeat (10) tick();
        chk("press_count", int'(step_count), 1);

        // Bounce on press and release
        do_reset();
        bounce = '{1, 0, 1, 1, 0, 1};
        for (int i = 0; i < 6; i++) begin
            btn_raw = bounce[i];
            tick();
        end
        btn_raw = 1'b1;
        repeat (10) tick();
        for (int i = 0; i < 6; i++) begin
            btn_raw = !bounce[i];
            tick();
        end
        btn_raw = 1'b0;
        repeat (10) tick();
        chk("bounce_count", int'(step_count), 1);
        chk("bounce_level", int'(btn_level), 0);

        // Free-run with halt and an ignored press
        do_reset();
        pulses = 0;
        third = 0;
        run_mode = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            halt = (k >= 20 && k <= 22);
            btn_raw = (k >= 30 && k < 42);
            tick();
            if (step_en) begin
                pulses++;
                if (k == 10) chk("run_first", k, 10);
                if (pulses == 3) third = k;
            end
        end
        chk("run_pulses", pulses, 4);
        chk("halt_delay", third, 29);
        halt = 1'b0;
        btn_raw = 1'b0;
        run_mode = 1'b0;
        repeat (12) tick();

        // Counter wrap after 17 run pulses
        do_reset();
        run_mode = 1'b1;
        for (int k = 1; k <= 139; k++) begin
            tick();
            if (k == 123) chk("wrap_15", int'(step_count), 15);
            if (k == 131) chk("wrap_0", int'(step_count), 0);
            if (k == 139) chk("wrap_1", int'(step_count), 1);
        end
        run_mode = 1'b0;
        repeat (4) tick();

        // Reset while in PRESS_WAIT with the button held
        do_reset();
        btn_raw = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_step_en", int'(step_en), 0);
        chk("midrst_count", int'(step_count), 0);
        chk("midrst_level", int'(btn_level), 0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("midrst_edge", int'(step_en), int'(k == 7));
        end
        chk("midrst_total", int'(step_count), 1);
        btn_raw = 1'b0;
        repeat (10) tick();

        // Leave run mode exactly at the divider terminal count
        do_reset();
        run_mode = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            run_mode = (k <= 7);
            tick();
        end
        chk("switch_nopulse", int'(step_count), 0);
        btn_raw = 1'b1;
        repeat (12) tick();
        btn_raw = 1'b0;
        repeat (10) tick();
        chk("switch_manual", int'(step_count), 1);

        // Random bursts of button, mode, halt and occasional reset
        btn_left = 0;
        run_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (btn_left == 0) begin
                btn_raw = $urandom_range(0, 1);
                btn_left = $urandom_range(1, 12);
            end
            btn_left--;
            if (run_left == 0) begin
                run_mode = ($urandom_range(0, 2) == 0);
                run_left = $urandom_range(20, 120);
            end
            run_left--;
            halt = ($urandom_range(0, 4) == 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
